// File: rtl/dac_spi_out.sv
// Serial DAC output stage: 8-bit signed samples become offset-binary 16-bit
// command words shifted MSB first over CS_N/SCLK/MOSI, via a one-entry pending buffer.
module dac_spi_out #(
    parameter int         CLK_DIV = 2,
    parameter logic [3:0] CMD     = 4'b0011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_sample,
    input  logic       in_strobe,
    output logic       busy,
    output logic       pending,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic [7:0] overrun_cnt
);

    localparam int            DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t               r_state;
    logic signed [7:0]    r_buf;
    logic [15:0]          r_shift;
    logic [3:0]           r_bit;
    logic [DW-1:0]        r_div;
    logic [15:0]          w_word;
    logic                 w_consume;

    function automatic logic [7:0] to_offset(input logic signed [7:0] s);
        return s ^ 8'h80;
    endfunction

    assign w_word    = {CMD, to_offset(r_buf), 4'h0};
    assign w_consume = (r_state == IDLE) && pending;

    // Sample data carries no reset; only the valid flag and counter do.
    always_ff @(posedge clk) begin
        if (in_strobe) begin
            r_buf <= in_sample;
        end
    end

    // A strobe landing on the IDLE load refills the buffer rather than overwriting it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else if (in_strobe) begin
            pending <= 1'b1;
            if (pending && !w_consume && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end else if (w_consume) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_shift  <= 16'h0000;
            r_bit    <= 4'd0;
            r_div    <= '0;
            busy     <= 1'b0;
            dac_cs_n <= 1'b1;
            dac_sclk <= 1'b0;
            dac_mosi <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    dac_cs_n <= 1'b1;
                    dac_sclk <= 1'b0;
                    if (pending) begin
                        r_shift  <= w_word;
                        dac_mosi <= w_word[15];
                        dac_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        r_div    <= DIV_LAST;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_div == '0) begin
                        r_div   <= DIV_LAST;
                        r_bit   <= 4'd15;
                        r_state <= SHIFT;
                    end else begin
                        r_div <= r_div - DW'(1);
                    end
                end
                SHIFT: begin
                    if (r_div != '0) begin
                        r_div <= r_div - DW'(1);
                    end else begin
                        r_div <= DIV_LAST;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else begin
                            dac_sclk <= 1'b0;
                            if (r_bit == 4'd0) begin
                                dac_cs_n <= 1'b1;
                                r_state  <= HOLD;
                            end else begin
                                // Rotate so the register drains MSB first onto MOSI.
                                r_bit    <= r_bit - 4'd1;
                                r_shift  <= {r_shift[14:0], r_shift[15]};
                                dac_mosi <= r_shift[14];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (r_div == '0) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_div <= r_div - DW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_out.sv
// Directed bench for dac_spi_out: three instances (default, CMD=4'hA, CLK_DIV=1)
// share the sample stream; a negedge monitor reassembles each SPI frame.
module tb_dac_spi_out;

    logic       clk;
    logic       rst;
    logic [7:0] in_sample;
    logic       in_strobe;

    logic       busy_o [3];
    logic       pend_o [3];
    logic       cs_o   [3];
    logic       sclk_o [3];
    logic       mosi_o [3];
    logic [7:0] ovr_o  [3];

    dac_spi_out #(.CLK_DIV(2), .CMD(4'b0011)) u_dut (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_strobe(in_strobe),
        .busy(busy_o[0]), .pending(pend_o[0]), .dac_cs_n(cs_o[0]),
        .dac_sclk(sclk_o[0]), .dac_mosi(mosi_o[0]), .overrun_cnt(ovr_o[0])
    );

    dac_spi_out #(.CLK_DIV(2), .CMD(4'b1010)) u_cmd (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_strobe(in_strobe),
        .busy(busy_o[1]), .pending(pend_o[1]), .dac_cs_n(cs_o[1]),
        .dac_sclk(sclk_o[1]), .dac_mosi(mosi_o[1]), .overrun_cnt(ovr_o[1])
    );

    dac_spi_out #(.CLK_DIV(1), .CMD(4'b0011)) u_div1 (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_strobe(in_strobe),
        .busy(busy_o[2]), .pending(pend_o[2]), .dac_cs_n(cs_o[2]),
        .dac_sclk(sclk_o[2]), .dac_mosi(mosi_o[2]), .overrun_cnt(ovr_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame monitor: all outputs are registered, so one sample per negedge sees every cycle.
    int          cyc = 0;
    int          nfall[3], nframe[3], cur_rises[3], last_rises[3], bad[3];
    int          fall_cyc[3], cs_rise_cyc[3], last_cslow[3], last_gap[3], last_period[3];
    int          rise1[3], rise2[3], busy_start[3], busy_end[3], last_busy_len[3], last_idle_len[3];
    logic [15:0] cur_word[3], last_word[3], prev_word[3];
    logic        p_cs[3]   = '{1'b1, 1'b1, 1'b1};
    logic        p_sclk[3] = '{1'b0, 1'b0, 1'b0};
    logic        p_busy[3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (p_cs[i] && !cs_o[i]) begin
                nfall[i]++;
                last_period[i] = cyc - fall_cyc[i];
                last_gap[i]    = cyc - cs_rise_cyc[i];
                fall_cyc[i]    = cyc;
                cur_rises[i]   = 0;
                cur_word[i]    = 16'h0000;
            end
            if (!p_cs[i] && cs_o[i]) begin
                last_cslow[i]  = cyc - fall_cyc[i];
                prev_word[i]   = last_word[i];
                last_word[i]   = cur_word[i];
                last_rises[i]  = cur_rises[i];
                if (cur_rises[i] != 16) bad[i]++;
                nframe[i]++;
                cs_rise_cyc[i] = cyc;
            end
            if (!p_sclk[i] && sclk_o[i]) begin
                cur_word[i] = {cur_word[i][14:0], mosi_o[i]};
                cur_rises[i]++;
                if (cur_rises[i] == 1) rise1[i] = cyc;
                if (cur_rises[i] == 2) rise2[i] = cyc;
            end
            if (!p_busy[i] && busy_o[i]) begin
                last_idle_len[i] = cyc - busy_end[i];
                busy_start[i]    = cyc;
            end
            if (p_busy[i] && !busy_o[i]) begin
                last_busy_len[i] = cyc - busy_start[i];
                busy_end[i]      = cyc;
            end
            p_cs[i]   = cs_o[i];
            p_sclk[i] = sclk_o[i];
            p_busy[i] = busy_o[i];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] s);
        in_sample = s;
        in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int b;
        b = 0;
        while (nframe[0] < target && b < budget) begin
            tick();
            b++;
        end
        chk(tag, nframe[0], target);
    endtask

    int base;
    int c0;
    int nf;
    int b;

    initial begin
        rst       = 1'b1;
        in_strobe = 1'b0;
        in_sample = 8'h00;
        #2 rst = 1'b0;

        // Reset held while the strobe toggles
        repeat (10) begin
            tick();
            in_strobe = ~in_strobe;
            in_sample = in_sample + 8'h13;
        end
        tick();
        chk("rst_cs_n",    cs_o[0],   1'b1);
        chk("rst_sclk",    sclk_o[0], 1'b0);
        chk("rst_mosi",    mosi_o[0], 1'b0);
        chk("rst_busy",    busy_o[0], 1'b0);
        chk("rst_pending", pend_o[0], 1'b0);
        chk("rst_overrun", ovr_o[0],  8'd0);
        in_strobe = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // Single sample 0x00
        base = nframe[0];
        c0   = cyc;
        strobe(8'h00);
        wait_frames(base + 1, 200, "single_done");
        repeat (5) tick();
        chk("single_word",     last_word[0],          16'h3800);
        chk("single_rises",    last_rises[0],         16);
        chk("single_cs_low",   last_cslow[0],         66);
        chk("single_busy_len", last_busy_len[0],      68);
        chk("single_latency",  fall_cyc[0] - c0,      2);
        chk("single_first_up", rise1[0] - fall_cyc[0], 4);
        chk("cmdA_word_00",    last_word[1],          16'hA800);
        chk("div1_cs_low",     last_cslow[2],         33);

        // Boundary samples back to back
        base = nframe[0];
        strobe(8'h80);
        repeat (4) tick();
        strobe(8'h7F);
        wait_frames(base + 2, 400, "bound_done");
        repeat (5) tick();
        chk("bound_word_80",  prev_word[0],     16'h3000);
        chk("bound_word_7f",  last_word[0],     16'h3FF0);
        chk("bound_cs_gap",   last_gap[0],      3);
        chk("bound_idle",     last_idle_len[0], 1);
        chk("bound_period",   last_period[0],   69);
        chk("cmdA_word_80",   prev_word[1],     16'hA000);
        chk("div1_period",    last_period[2],   35);
        chk("div1_word_7f",   last_word[2],     16'h3FF0);
        chk("div1_half_per",  rise2[2] - rise1[2], 2);
        chk("div2_bit_per",   rise2[0] - rise1[0], 4);
        chk("bound_no_ovr",   ovr_o[0],         8'd0);

        // Three strobes during one frame
        base = nframe[0];
        strobe(8'h55);
        repeat (6) tick();
        strobe(8'h11);
        strobe(8'h22);
        strobe(8'h33);
        tick();
        chk("ovr_count",    ovr_o[0],  8'd2);
        chk("ovr_pending",  pend_o[0], 1'b1);
        chk("div1_ovr",     ovr_o[2],  8'd2);
        wait_frames(base + 2, 400, "ovr_done");
        repeat (5) tick();
        chk("ovr_first",    prev_word[0], 16'h3D50);
        chk("ovr_last",     last_word[0], 16'h3B30);

        // Strobe coinciding with the IDLE load
        base = nframe[0];
        in_sample = 8'h01;
        in_strobe = 1'b1;
        tick();
        in_sample = 8'h02;
        tick();
        in_strobe = 1'b0;
        tick();
        chk("coinc_no_ovr",  ovr_o[0],  8'd2);
        chk("coinc_pending", pend_o[0], 1'b1);
        wait_frames(base + 2, 400, "coinc_done");
        repeat (5) tick();
        chk("coinc_word1",   prev_word[0], 16'h3810);
        chk("coinc_word2",   last_word[0], 16'h3820);
        chk("coinc_gap",     last_gap[0],  3);

        // Strobe every cycle for 300 frames
        base = nframe[0];
        in_strobe = 1'b1;
        b = 0;
        while (nframe[0] < base + 300 && b < 22000) begin
            in_sample = in_sample + 8'd7;
            tick();
            b++;
        end
        in_strobe = 1'b0;
        chk("cont_frames",   nframe[0], base + 300);
        chk("cont_sat",      ovr_o[0],  8'd255);
        chk("cont_sat_div1", ovr_o[2],  8'd255);
        chk("cont_bits",     bad[0],    0);
        chk("cont_bits_d1",  bad[2],    0);
        repeat (150) tick();

        // Reset during SHIFT bit 7 with a sample waiting
        strobe(8'h5A);
        repeat (6) tick();
        strobe(8'h66);
        b = 0;
        while (!(cur_rises[0] == 8 && !sclk_o[0] && !cs_o[0]) && b < 200) begin
            tick();
            b++;
        end
        chk("abort_at_bit7", cur_rises[0], 8);
        rst = 1'b0;
        #1;
        chk("abort_cs_n",    cs_o[0],   1'b1);
        chk("abort_sclk",    sclk_o[0], 1'b0);
        chk("abort_mosi",    mosi_o[0], 1'b0);
        chk("abort_busy",    busy_o[0], 1'b0);
        chk("abort_pending", pend_o[0], 1'b0);
        chk("abort_overrun", ovr_o[0],  8'd0);
        tick();
        tick();
        rst = 1'b1;
        nf = nfall[0];
        repeat (300) tick();
        chk("abort_quiet",   nfall[0] - nf, 0);
        chk("abort_cs_idle", cs_o[0], 1'b1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
